// File: rtl/axi_tb_pkg.sv
// Shared types for the testbench AXI slave model: slot record, scheduler FSM states, rdata pattern.
// The slot id field is sized for the widest ID any instance may use (ID_MAX_W); narrower IDs are zero-extended.
package axi_tb_pkg;

  localparam int ID_MAX_W = 16;

  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [3:0]          len;
    logic [3:0]          beat;
  } rd_slot_t;

  // The pattern lets a checker tell which burst and beat a data word came from.
  function automatic logic [ID_MAX_W+3:0] mk_rdata(input logic [ID_MAX_W-1:0] id,
                                                   input logic [3:0]          beat);
    return {id, beat};
  endfunction

endpackage

// File: rtl/axi_rd_rsp_sched_rr_arbiter.sv
// Round-robin pick: the first set request at or after ptr, wrapping; combinational, no backpressure.
// N must be a power of two so the index arithmetic wraps on its own.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = found;
  end

endmodule

// File: rtl/axi_rd_rsp_sched.sv
// AR table + R-channel scheduler: AR->first rvalid 2 cycles, one bubble between bursts; R holds while !rready, arready drops when full.
// Define RD_INTERLEAVE_EN to re-arbitrate after every beat instead of holding R until rlast.
module axi_rd_rsp_sched
  import axi_tb_pkg::*;
#(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32,
  parameter int OSTD_NUM   = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        srst,
  input  logic                        in_arvalid,
  output logic                        out_arready,
  input  logic [AXI_ID_W-1:0]         in_arid,
  input  logic [3:0]                  in_arlen,
  output logic                        out_rvalid,
  input  logic                        in_rready,
  output logic [AXI_ID_W-1:0]         out_rid,
  output logic [AXI_DATA_W-1:0]       out_rdata,
  output logic [1:0]                  out_rresp,
  output logic                        out_rlast,
  output logic [$clog2(OSTD_NUM):0]   out_ostd_cnt
);

  localparam int IDX_W = $clog2(OSTD_NUM);
  localparam int CNT_W = IDX_W + 1;

  rd_slot_t            slot_q  [OSTD_NUM];
  logic [OSTD_NUM-1:0] older_q [OSTD_NUM];
  rd_state_e           state_q, state_d;
  logic [IDX_W-1:0]    cur_q, rr_ptr_q, free_idx, arb_idx;
  logic [OSTD_NUM-1:0] elig, arb_gnt;
  logic                arready_q, ar_fire, r_fire, last_beat, grant_take;
  logic [CNT_W-1:0]    cnt, cnt_next;
  rd_slot_t            cur_slot;

  // A slot may send only when no older live slot carries the same ID.
  always_comb begin
    elig = '0;
    for (int i = 0; i < OSTD_NUM; i++) begin
      elig[i] = slot_q[i].valid;
      for (int j = 0; j < OSTD_NUM; j++) begin
        if (slot_q[j].valid && older_q[j][i] && (slot_q[j].id == slot_q[i].id)) begin
          elig[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    free_idx = '0;
    cnt      = '0;
    for (int i = OSTD_NUM - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        free_idx = IDX_W'(i);
      end
      cnt = cnt + CNT_W'(slot_q[i].valid);
    end
  end

  assign cur_slot     = slot_q[cur_q];
  assign ar_fire      = in_arvalid & arready_q;
  assign r_fire       = (state_q == SEND) & in_rready;
  assign last_beat    = (cur_slot.beat == cur_slot.len);
  assign cnt_next     = cnt + CNT_W'(ar_fire) - CNT_W'(r_fire & last_beat);
  assign out_arready  = arready_q;
  assign out_ostd_cnt = cnt;
  assign out_rresp    = OKAY;

  rr_arbiter #(
    .N (OSTD_NUM)
  ) u_rr_arbiter (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    out_rvalid = 1'b0;
    out_rid    = '0;
    out_rdata  = '0;
    out_rlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          grant_take = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        out_rvalid = 1'b1;
        out_rid    = cur_slot.id[AXI_ID_W-1:0];
        out_rdata  = AXI_DATA_W'(mk_rdata(cur_slot.id, cur_slot.beat));
        out_rlast  = last_beat;
`ifdef RD_INTERLEAVE_EN
        if (in_rready) begin
          state_d = IDLE;
        end
`else
        if (in_rready && last_beat) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else if (srst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < OSTD_NUM; i++) begin
        slot_q[i]  <= '0;
        older_q[i] <= '0;
      end
      cur_q     <= '0;
      rr_ptr_q  <= '0;
      arready_q <= 1'b0;
    end else if (srst) begin
      for (int i = 0; i < OSTD_NUM; i++) begin
        slot_q[i]  <= '0;
        older_q[i] <= '0;
      end
      cur_q     <= '0;
      rr_ptr_q  <= '0;
      arready_q <= 1'b0;
    end else begin
      if (ar_fire) begin
        slot_q[free_idx]  <= '{valid: 1'b1, id: ID_MAX_W'(in_arid), len: in_arlen, beat: 4'd0};
        older_q[free_idx] <= '0;
        for (int k = 0; k < OSTD_NUM; k++) begin
          older_q[k][free_idx] <= slot_q[k].valid;
        end
      end
      // Freeing comes after the alloc writes so a slot retiring this cycle never ends up older than the new one.
      if (r_fire) begin
        if (last_beat) begin
          slot_q[cur_q]  <= '0;
          older_q[cur_q] <= '0;
          for (int k = 0; k < OSTD_NUM; k++) begin
            older_q[k][cur_q] <= 1'b0;
          end
        end else begin
          slot_q[cur_q].beat <= cur_slot.beat + 4'd1;
        end
      end
      if (grant_take) begin
        cur_q    <= arb_idx;
        rr_ptr_q <= arb_idx + IDX_W'(1);
      end
      arready_q <= (cnt_next < CNT_W'(OSTD_NUM));
    end
  end

endmodule

// File: tb/tb_axi_rd_rsp_sched.sv
// Bench for axi_rd_rsp_sched: directed vector table, hand-built corner sequences, then random traffic vs a slot/sequence-number model.
module tb_axi_rd_rsp_sched;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int N      = 4;
  localparam int CNT_W  = $clog2(N) + 1;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic              srst = 1'b0;
  logic              in_arvalid = 1'b0;
  logic              in_rready = 1'b0;
  logic [ID_W-1:0]   in_arid = '0;
  logic [3:0]        in_arlen = '0;
  logic              out_arready, out_rvalid, out_rlast;
  logic [ID_W-1:0]   out_rid;
  logic [DATA_W-1:0] out_rdata;
  logic [1:0]        out_rresp;
  logic [CNT_W-1:0]  out_ostd_cnt;

  always #5 aclk = ~aclk;

  axi_rd_rsp_sched #(
    .AXI_ID_W   (ID_W),
    .AXI_DATA_W (DATA_W),
    .OSTD_NUM   (N)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .srst         (srst),
    .in_arvalid   (in_arvalid),
    .out_arready  (out_arready),
    .in_arid      (in_arid),
    .in_arlen     (in_arlen),
    .out_rvalid   (out_rvalid),
    .in_rready    (in_rready),
    .out_rid      (out_rid),
    .out_rdata    (out_rdata),
    .out_rresp    (out_rresp),
    .out_rlast    (out_rlast),
    .out_ostd_cnt (out_ostd_cnt)
  );

  int passed = 0;
  int total  = 0;
  int r_ids[$];
  int r_data[$];
  int last_ids[$];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: live bursts tagged with arrival sequence numbers.
  bit m_v[N];
  int m_id[N], m_len[N], m_beat[N], m_seq[N];
  int m_ctr, m_rr, m_cur;
  bit m_busy, m_ardy;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_id[i] = 0; m_len[i] = 0; m_beat[i] = 0; m_seq[i] = 0;
    end
    m_ctr = 0; m_rr = 0; m_cur = 0; m_busy = 0; m_ardy = 0;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) c++;
    return c;
  endfunction

  function automatic bit m_elig(int i);
    if (!m_v[i]) return 0;
    for (int j = 0; j < N; j++)
      if (m_v[j] && m_id[j] == m_id[i] && m_seq[j] < m_seq[i]) return 0;
    return 1;
  endfunction

  function automatic void m_step(int arv, int arid, int arlen, int rr);
    bit ar_f, r_f, was_busy;
    int fr, g;
    ar_f = (arv != 0) && m_ardy;
    r_f  = m_busy && (rr != 0);
    was_busy = m_busy;
    fr = -1;
    g  = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_v[i]) fr = i;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && m_elig(i)) g = i;
      end
    end
    if (r_f) begin
      if (m_beat[m_cur] == m_len[m_cur]) begin
        m_v[m_cur] = 0;
        m_busy = 0;
      end else begin
        m_beat[m_cur]++;
`ifdef RD_INTERLEAVE_EN
        m_busy = 0;
`endif
      end
    end
    if (!was_busy && g >= 0) begin
      m_busy = 1; m_cur = g; m_rr = (g + 1) % N;
    end
    if (ar_f && fr >= 0) begin
      m_v[fr] = 1; m_id[fr] = arid; m_len[fr] = arlen; m_beat[fr] = 0;
      m_seq[fr] = m_ctr; m_ctr++;
    end
    m_ardy = (m_cnt() < N);
  endfunction

  task automatic model_check();
    chk("arready", int'(out_arready), int'(m_ardy));
    chk("rvalid", int'(out_rvalid), int'(m_busy));
    chk("rid", int'(out_rid), m_busy ? m_id[m_cur] : 0);
    chk("rdata", int'(out_rdata), m_busy ? m_id[m_cur] * 16 + m_beat[m_cur] : 0);
    chk("rlast", int'(out_rlast), int'(m_busy && m_beat[m_cur] == m_len[m_cur]));
    chk("ostd_cnt", int'(out_ostd_cnt), m_cnt());
    chk("rresp", int'(out_rresp), 0);
  endtask

  // Called at posedge+1: sample this cycle's outputs, drive inputs, advance one clock.
  task automatic cycle(int arv, int arid, int arlen, int rr, bit do_chk);
    if (do_chk) model_check();
    if (out_rvalid && rr != 0) begin
      r_ids.push_back(int'(out_rid));
      r_data.push_back(int'(out_rdata));
      if (out_rlast) last_ids.push_back(int'(out_rid));
    end
    in_arvalid = (arv != 0);
    in_arid    = ID_W'(arid);
    in_arlen   = 4'(arlen);
    in_rready  = (rr != 0);
    @(posedge aclk);
    m_step(arv, arid, arlen, rr);
    #1;
  endtask

  task automatic do_reset();
    in_arvalid = 0; in_rready = 0; srst = 0;
    aresetn = 0;
    m_reset();
    #1;
    chk("reset rvalid", int'(out_rvalid), 0);
    chk("reset arready", int'(out_arready), 0);
    chk("reset ostd_cnt", int'(out_ostd_cnt), 0);
    chk("reset rlast", int'(out_rlast), 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
  endtask

  task automatic send_ar(int id, int len, int rr);
    bit ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      ok = out_arready;
      cycle(1, id, len, rr, 1);
    end
    chk("ar accepted", int'(ok), 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (out_ostd_cnt != 0 || out_rvalid); t++) cycle(0, 0, 0, 1, 1);
    chk("drain ostd_cnt", int'(out_ostd_cnt), 0);
  endtask

  typedef struct {
    int arv, id, len, rr;
    int ardy, rv, rid, rdata, rlast, cnt;
  } vec_t;

  vec_t tbl[8];
  int   exp56[6];
  int   ord[4];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    bit hit;
    #2;
    do_reset();

    // Single burst id=3 len=3: arready one cycle after reset, four beats, then empty.
    tbl[0] = '{1, 3, 3, 1,  0, 0, 0, 'h00, 0, 0};
    tbl[1] = '{1, 3, 3, 1,  1, 0, 0, 'h00, 0, 0};
    tbl[2] = '{0, 0, 0, 1,  1, 0, 0, 'h00, 0, 1};
    tbl[3] = '{0, 0, 0, 1,  1, 1, 3, 'h30, 0, 1};
    tbl[4] = '{0, 0, 0, 1,  1, 1, 3, 'h31, 0, 1};
    tbl[5] = '{0, 0, 0, 1,  1, 1, 3, 'h32, 0, 1};
    tbl[6] = '{0, 0, 0, 1,  1, 1, 3, 'h33, 1, 1};
    tbl[7] = '{0, 0, 0, 1,  1, 0, 0, 'h00, 0, 0};
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("vec%0d arready", r), int'(out_arready), tbl[r].ardy);
      chk($sformatf("vec%0d rvalid", r), int'(out_rvalid), tbl[r].rv);
      chk($sformatf("vec%0d rid", r), int'(out_rid), tbl[r].rid);
      chk($sformatf("vec%0d rdata", r), int'(out_rdata), tbl[r].rdata);
      chk($sformatf("vec%0d rlast", r), int'(out_rlast), tbl[r].rlast);
      chk($sformatf("vec%0d ostd_cnt", r), int'(out_ostd_cnt), tbl[r].cnt);
      cycle(tbl[r].arv, tbl[r].id, tbl[r].len, tbl[r].rr, 0);
    end

    // ids 1,2,1,2 len=1 while R is stalled: table fills, completions keep per-ID and RR order.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    ord = '{1, 2, 1, 2};
    foreach (ord[i]) send_ar(ord[i], 1, 0);
    chk("ord arready_full", int'(out_arready), 0);
    chk("ord ostd_full", int'(out_ostd_cnt), 4);
    last_ids.delete();
    drain();
    chk("ord burst count", last_ids.size(), 4);
    foreach (ord[i]) if (i < last_ids.size()) chk($sformatf("ord burst%0d id", i), last_ids[i], ord[i]);

    // Full table, refill on the cycle arready returns, then AR together with rlast.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    for (int id = 4; id < 8; id++) send_ar(id, 0, 0);
    chk("full arready", int'(out_arready), 0);
    chk("full ostd_cnt", int'(out_ostd_cnt), 4);
    send_ar(8, 0, 1);
    chk("refill ostd_cnt", int'(out_ostd_cnt), 4);
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      hit = out_rvalid && out_rlast && out_arready;
      if (!hit) cycle(0, 0, 0, 1, 1);
    end
    chk("sim rlast+arready seen", int'(hit), 1);
    cycle(1, 9, 0, 1, 1);
    chk("sim ostd_cnt", int'(out_ostd_cnt), 3);
    drain();

    // 8-beat burst with random rready: every beat once, in order.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    send_ar(9, 7, 0);
    r_data.delete();
    for (int t = 0; t < 300 && r_data.size() < 8; t++) cycle(0, 0, 0, int'($urandom_range(0, 1)), 1);
    chk("stall beats", r_data.size(), 8);
    foreach (r_data[i]) if (i < 8) chk($sformatf("stall beat%0d", i), r_data[i], 'h90 + i);

    // Async reset on beat 2 of 4, then a fresh burst starts at beat 0.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    send_ar(7, 3, 1);
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      hit = out_rvalid && (out_rdata == 32'h72);
      if (!hit) cycle(0, 0, 0, 1, 1);
    end
    chk("areset beat2 seen", int'(hit), 1);
    do_reset();
    cycle(0, 0, 0, 0, 1);
    r_data.delete();
    send_ar(7, 3, 1);
    for (int t = 0; t < 20 && r_data.size() == 0; t++) cycle(0, 0, 0, 1, 1);
    chk("after areset first beat", r_data.size() > 0 ? r_data[0] : -1, 'h70);

    // Sync reset mid-burst.
    cycle(0, 0, 0, 0, 1);
    in_arvalid = 0; in_rready = 0; srst = 1;
    @(posedge aclk);
    m_reset();
    #1 srst = 0;
    chk("srst rvalid", int'(out_rvalid), 0);
    chk("srst arready", int'(out_arready), 0);
    chk("srst ostd_cnt", int'(out_ostd_cnt), 0);
    cycle(0, 0, 0, 1, 1);
    chk("srst arready back", int'(out_arready), 1);

    // ids 5 and 6, len=2: interleaved or back-to-back depending on build.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    r_ids.delete();
    send_ar(5, 2, 1);
    send_ar(6, 2, 1);
    drain();
`ifdef RD_INTERLEAVE_EN
    exp56 = '{5, 6, 5, 6, 5, 6};
`else
    exp56 = '{5, 5, 5, 6, 6, 6};
`endif
    chk("id56 beat count", r_ids.size(), 6);
    foreach (exp56[i]) if (i < r_ids.size()) chk($sformatf("id56 beat%0d rid", i), r_ids[i], exp56[i]);

    // Random traffic over a small ID set to stress same-ID ordering.
    do_reset();
    for (int t = 0; t < 3000; t++)
      cycle(int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 3) != 0), 1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_rd_rsp_sched.md
Name: axi_rd_rsp_sched

Overview:
- Read-response scheduler for the testbench AXI slave model.
- Accepts AR requests into an outstanding-request table and drives the R channel.
- Picks which outstanding burst sends next using round-robin over slots that are eligible to send.
- Keeps AXI same-ID ordering, lets different IDs go out of order, and generates a deterministic, self-checking rdata pattern.

Parameters:
- AXI_ID_W, 4, ARID/RID width.
- AXI_DATA_W, 32, RDATA width; must be >= AXI_ID_W+4.
- OSTD_NUM, 4, outstanding-request table depth; power of 2, >= 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- srst  in  1  sync active-high reset; same effect as aresetn, applied at the clock edge
- in_arvalid  in  1  AR valid
- out_arready  out  1  AR ready
- in_arid  in  AXI_ID_W  AR ID
- in_arlen  in  4  AR burst length minus 1
- out_rvalid  out  1  R valid
- in_rready  in  1  R ready
- out_rid  out  AXI_ID_W  R ID
- out_rdata  out  AXI_DATA_W  R data
- out_rresp  out  2  R response; always 2'b00
- out_rlast  out  1  last beat of burst
- out_ostd_cnt  out  clog2(OSTD_NUM)+1  number of occupied slots

Behaviour:
- Reset: aresetn is asynchronous, active-low; clock is aclk. aresetn low or srst high clears all slot valids, the age matrix, the RR pointer and the FSM state (goes to IDLE). All outputs reset to 0, including out_arready. Reset in the middle of a burst drops it silently.
- Slot table fields per slot: valid, id, len[3:0], beat[3:0]. Age matrix older[i][j] marks that slot i is older than slot j.
- AR accept:
  - out_arready is registered: next value = 1 when at least one slot is free after this cycle's alloc/free.
  - On arvalid && arready, the lowest free slot is written with id, len, beat=0. older[k][new] is set for every slot k that is valid.
  - A slot freed this cycle is not reused until the next cycle.
- Eligible slot: valid, and no valid older slot with the same id.
- FSM state IDLE:
  - If any slot is eligible, grant the first eligible slot at or after rr_ptr (wrapping), store it as cur, set rr_ptr = cur+1 mod OSTD_NUM, go to SEND.
  - Otherwise stay in IDLE.
- FSM state SEND:
  - out_rvalid=1; out_rid=cur.id; out_rlast=(cur.beat==cur.len).
  - out_rdata = zero-extended {cur.id, cur.beat}.
  - rid, rdata and rlast are stable while rvalid && !rready.
  - On handshake (rvalid && rready): beat increments. If it was the last beat, the slot is freed, its age row/column is cleared, and the FSM goes to IDLE. Otherwise it stays in SEND (default).
- Timing: one bubble cycle between bursts. Minimum latency from AR handshake to first rvalid is 2 cycles.
- Simultaneous AR accept and rlast handshake are both applied. out_ostd_cnt is unchanged in that cycle.
- arlen=0 gives a single beat with rlast=1.
- When the table is full, arready=0 until a burst completes.

Optional Feature:
- Macro RD_INTERLEAVE_EN.
- Defined: after every non-last beat handshake the FSM returns to IDLE and re-arbitrates, so bursts of different IDs interleave beat-by-beat (one bubble per beat).
- Undefined: a granted burst holds the R channel until rlast.

Decomposition:
- Shared package axi_tb_pkg:
  - rresp constant OKAY=2'b00.
  - Typedef rd_slot_t {valid, id, len, beat}.
  - FSM enum {IDLE, SEND}.
  - Function mk_rdata(id, beat).
- One sub-module, rr_arbiter (request vector, pointer -> one-hot grant + index), reused for future B-channel scheduling.

Test Plan:
- Single AR id=3 len=3, rready=1 -> arready high 1 cycle after reset; 4 beats rid=3, rdata=0x30..0x33, rlast on 4th beat; ostd_cnt 1->0.
- 4 ARs ids 1,2,1,2 len=1 back-to-back -> arready drops after 4th; R order per ID kept (first id1 burst before second id1 burst); RR order across IDs is 1,2,1,2.
- Table full plus simultaneous AR and rlast -> new AR accepted the cycle arready returns; ostd_cnt stays 4.
- rready toggling randomly during an 8-beat burst -> rid/rdata/rlast stable while stalled, no beat lost or duplicated.
- Assert aresetn mid-burst (beat 2 of 4) -> rvalid/arready go to 0 immediately, ostd_cnt=0; a fresh AR after reset starts at beat 0.
- With RD_INTERLEAVE_EN: ids 5 and 6, len=2 -> beats alternate 5,6,5,6,5,6 with one idle cycle between beats; without the macro -> 5,5,5, then 6,6,6.
